// File: rtl/oka16_seq_ctrl.sv
// oka16_seq_ctrl: sequences three Karatsuba sub-products through one shared 8x8 carry-less multiplier
module oka16_seq_ctrl #(
  parameter int MUL_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [30:0]      out_y,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [14:0]      mul_y,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);
  if (MUL_LAT != 0 && MUL_LAT != 1) begin : g_bad_lat
    $error("oka16_seq_ctrl: MUL_LAT must be 0 or 1");
  end
  typedef enum logic [2:0] {IDLE, P0, P1, P2, DONE} state_t;
  state_t           state_q, state_d;
  logic [7:0]       al_q, al_d, ah_q, ah_d, bl_q, bl_d, bh_q, bh_d;
  logic [7:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [30:0]      acc_q, acc_d, out_y_q, out_y_d, z, acc_p2;
  logic             out_valid_q, out_valid_d, cap_q, cap_d, cap, accept, take;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  assign in_ready  = rst_n && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign take      = out_valid_q && out_ready;
  assign z         = {16'b0, mul_y};
  assign cap       = (MUL_LAT == 0) || cap_q;
  assign acc_p2    = acc_q ^ (z << 8) ^ (z << 16);
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = state_q != IDLE;
  assign op_cnt    = op_cnt_q;
  // next-state, operand drive and accumulation; each Pk waits for its capture cycle
  always_comb begin
    state_d     = state_q;
    al_d        = al_q;
    ah_d        = ah_q;
    bl_d        = bl_q;
    bh_d        = bh_q;
    acc_d       = acc_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    cap_d       = 1'b0;
    op_cnt_d    = op_cnt_q + CNT_W'(take);
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          {ah_d, al_d} = in_a;
          {bh_d, bl_d} = in_b;
          mul_a_d      = in_a[7:0];
          mul_b_d      = in_b[7:0];
          out_valid_d  = 1'b0;
          state_d      = P0;
        end else if (take) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      P0: begin
        cap_d = !cap;
        if (cap) begin
          acc_d   = z ^ (z << 8);
          mul_a_d = al_q ^ ah_q;
          mul_b_d = bl_q ^ bh_q;
          state_d = P1;
        end
      end
      P1: begin
        cap_d = !cap;
        if (cap) begin
          acc_d   = acc_q ^ (z << 8);
          mul_a_d = ah_q;
          mul_b_d = bh_q;
          state_d = P2;
        end
      end
      P2: begin
        cap_d = !cap;
        if (cap) begin
          acc_d       = acc_p2;
          out_y_d     = acc_p2;
          out_valid_d = 1'b1;
          mul_a_d     = 8'h00;
          mul_b_d     = 8'h00;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; reset discards any in-flight transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      al_q        <= '0;
      ah_q        <= '0;
      bl_q        <= '0;
      bh_q        <= '0;
      acc_q       <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      cap_q       <= 1'b0;
      op_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      al_q        <= al_d;
      ah_q        <= ah_d;
      bl_q        <= bl_d;
      bh_q        <= bh_d;
      acc_q       <= acc_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      cap_q       <= cap_d;
      op_cnt_q    <= op_cnt_d;
    end
  end
endmodule

// File: tb/tb_oka16_seq_ctrl.sv
// tb_oka16_seq_ctrl: directed and random checks of both multiplier latencies
module tb_oka16_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] in_a = '0, in_b = '0;
  logic iv0, iv1, ir0, ir1, ov0, ov1, bz0, bz1;
  logic [30:0] y0, y1;
  logic [7:0] ma0, ma1, mb0, mb1;
  logic [14:0] my0, my1;
  logic [15:0] cnt0, cnt1;
  logic in_ready, out_valid, busy;
  logic [30:0] out_y;
  logic [7:0] mul_a;
  logic [15:0] op_cnt;
  logic [7:0] seq [0:31];
  int checks = 0, failures = 0;
  int exp_cnt [2] = '{0, 0};
  always #5 clk = ~clk;
  function automatic logic [14:0] clmul8(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] r = '0;
    for (int i = 0; i < 8; i++) if (b[i]) r ^= 15'(a) << i;
    return r;
  endfunction
  function automatic logic [30:0] clmul16(input logic [15:0] a, input logic [15:0] b);
    logic [30:0] r = '0;
    for (int i = 0; i < 16; i++) if (b[i]) r ^= 31'(a) << i;
    return r;
  endfunction
  assign iv0 = in_valid & ~sel;
  assign iv1 = in_valid & sel;
  assign my0 = clmul8(ma0, mb0);
  always_ff @(posedge clk) my1 <= clmul8(ma1, mb1);
  assign in_ready  = sel ? ir1 : ir0;
  assign out_valid = sel ? ov1 : ov0;
  assign busy      = sel ? bz1 : bz0;
  assign out_y     = sel ? y1 : y0;
  assign mul_a     = sel ? ma1 : ma0;
  assign op_cnt    = sel ? cnt1 : cnt0;
  oka16_seq_ctrl #(.MUL_LAT(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_a(in_a), .in_b(in_b),
    .out_valid(ov0), .out_ready(out_ready), .out_y(y0), .mul_a(ma0), .mul_b(mb0),
    .mul_y(my0), .busy(bz0), .op_cnt(cnt0));
  oka16_seq_ctrl #(.MUL_LAT(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_a(in_a), .in_b(in_b),
    .out_valid(ov1), .out_ready(out_ready), .out_y(y1), .mul_a(ma1), .mul_b(mb1),
    .mul_y(my1), .busy(bz1), .op_cnt(cnt1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wait_done(input logic [30:0] e, input int lat, input string tag);
    int n = 1;
    while (!out_valid && n < 20) begin
      seq[n] = mul_a;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_y"}, out_y, e);
  endtask
  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [30:0] e, input int lat, input string tag);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    wait_done(e, lat, tag);
    if (out_ready) begin
      @(posedge clk); #1;
      exp_cnt[sel]++;
    end
  endtask
  initial begin
    logic [15:0] ra, rb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_out_y", out_y, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);
    run(16'h0003, 16'h0003, 31'h00000005, 4, "basic");
    chk("basic_ma_p0", seq[1], 8'h03);
    chk("basic_ma_p1", seq[2], 8'h03);
    chk("basic_ma_p2", seq[3], 8'h00);
    chk("basic_cnt", op_cnt, 1);
    chk("basic_idle_ma", mul_a, 0);
    chk("basic_idle_busy", busy, 0);
    run(16'hFFFF, 16'hFFFF, 31'h55555555, 4, "ffff");
    run(16'h8000, 16'h8000, 31'h40000000, 4, "bit30");
    run(16'h0101, 16'h0101, 31'h00010001, 4, "z1zero");
    run(16'h0100, 16'h0100, 31'h00010000, 4, "hi_only");
    chk("cnt5", op_cnt, 16'(exp_cnt[0]));
    out_ready = 1'b0;
    run(16'h0003, 16'h0005, 31'h0000000F, 4, "bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_y", out_y, 31'h0000000F);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_cnt", op_cnt, 16'(exp_cnt[0]));
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 16'h0101;
    in_b = 16'h0101;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_cnt[0]++;
    chk("b2b_cnt", op_cnt, 16'(exp_cnt[0]));
    chk("b2b_busy", busy, 1);
    chk("b2b_valid_low", out_valid, 0);
    wait_done(31'h00010001, 4, "b2b");
    @(posedge clk); #1;
    exp_cnt[0]++;
    chk("b2b_cnt2", op_cnt, 16'(exp_cnt[0]));
    sel = 1'b1;
    #1;
    run(16'hFFFF, 16'hFFFF, 31'h55555555, 7, "l1_ffff");
    run(16'h0003, 16'h0003, 31'h00000005, 7, "l1_basic");
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run(ra, rb, clmul16(ra, rb), 7, "l1_rnd");
    end
    chk("l1_cnt", op_cnt, 16'(exp_cnt[1]));
    sel = 1'b0;
    #1;
    in_a = 16'hFFFF;
    in_b = 16'hFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt[0] = 0;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_mul_a", mul_a, 0);
    chk("mid_busy0", busy, 0);
    chk("mid_cnt", op_cnt, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_no_out", out_valid, 0);
    run(16'h0100, 16'h0100, 31'h00010000, 4, "post_rst");
    run(16'hABCD, 16'h1234, clmul16(16'hABCD, 16'h1234), 4, "post_rst2");
    chk("post_rst_cnt", op_cnt, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
